// File: rtl/psram_bridge.sv
// psram_bridge: splits byte/half/word requests at any alignment into 16-bit PSRAM driver transactions.
// Optional one-halfword read buffer enabled by defining PSRAM_BRIDGE_RDBUF_EN.
module psram_bridge #(
   parameter int ADDR_WIDTH = 23
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  stb_i,
   input  logic                  we_i,
   input  logic [1:0]            size_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [31:0]           data_i,
   output logic                  ack_o,
   output logic [31:0]           data_o,
   output logic                  busy_o,
   output logic                  mem_stb_o,
   output logic                  mem_we_o,
   output logic [3:0]            mem_sel_o,
   output logic [ADDR_WIDTH-2:0] mem_addr_o,
   output logic [31:0]           mem_data_o,
   input  logic                  mem_ack_i,
   input  logic [31:0]           mem_data_i
);
   localparam int HW = ADDR_WIDTH - 1;
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
   state_t state, state_nx;
   logic we_q, odd_q;
   logic [1:0] n_q, k_q, sel0_q, sel, n_in;
   logic [HW-1:0] hw_q, seg_addr;
   logic [47:0] wstream_q, asm_q, asm_nx;
   logic [31:0] wmask;
   logic [15:0] rd_hw;
   logic active, last, hit, seg_done, capture;
   logic unused_ok;
   assign unused_ok = ^mem_data_i[31:16];
   assign n_in = size_i == 2'd0 ? 2'd1 : size_i == 2'd1 ? {1'b0, addr_i[0]} + 2'd1 : {1'b0, addr_i[0]} + 2'd2;
   assign wmask = size_i == 2'd0 ? {24'b0, data_i[7:0]} : size_i == 2'd1 ? {16'b0, data_i[15:0]} : data_i;
   assign seg_addr = hw_q + HW'(k_q);
   assign last = k_q == n_q - 2'd1;
   assign sel = k_q == 2'd0 ? sel0_q : (last && odd_q) ? 2'b01 : 2'b11;
   assign active = state == S_ISSUE || state == S_WAIT;
   assign seg_done = (state == S_WAIT && mem_ack_i) || hit;
   assign capture = seg_done && !we_q;
`ifdef PSRAM_BRIDGE_RDBUF_EN
   logic buf_v;
   logic [HW-1:0] buf_tag;
   logic [15:0] buf_data;
   // the buffer only ever holds full halfwords, so a tag match covers both lanes
   assign hit = state == S_ISSUE && !we_q && buf_v && buf_tag == seg_addr;
   assign rd_hw = hit ? buf_data : mem_data_i[15:0];
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         buf_v <= 1'b0;
         buf_tag <= '0;
         buf_data <= '0;
      end else if (state == S_WAIT && mem_ack_i && !we_q && sel == 2'b11) begin
         buf_v <= 1'b1;
         buf_tag <= seg_addr;
         buf_data <= mem_data_i[15:0];
      end else if (mem_stb_o && we_q && seg_addr == buf_tag) begin
         buf_v <= 1'b0;
      end
   end
`else
   assign hit = 1'b0;
   assign rd_hw = mem_data_i[15:0];
`endif
   assign mem_stb_o = state == S_ISSUE && !hit;
   assign mem_we_o = active && we_q;
   assign mem_sel_o = active ? {2'b00, sel} : 4'b0;
   assign mem_addr_o = active ? seg_addr : '0;
   assign mem_data_o = (active && we_q) ? {16'b0, wstream_q[{k_q, 4'b0} +: 16]} : 32'b0;
   assign ack_o = state == S_DONE;
   assign busy_o = state != S_IDLE;
   always_comb begin
      asm_nx = asm_q;
      if (capture && sel[0]) asm_nx[{k_q, 4'b0} +: 8] = rd_hw[7:0];
      if (capture && sel[1]) asm_nx[{k_q, 4'b0} + 6'd8 +: 8] = rd_hw[15:8];
   end
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  state_nx = stb_i ? S_ISSUE : S_IDLE;
         S_ISSUE: state_nx = hit ? (last ? S_DONE : S_ISSUE) : S_WAIT;
         S_WAIT:  state_nx = mem_ack_i ? (last ? S_DONE : S_ISSUE) : S_WAIT;
         default: state_nx = S_IDLE;
      endcase
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= S_IDLE;
         we_q <= 1'b0;
         odd_q <= 1'b0;
         n_q <= '0;
         k_q <= '0;
         sel0_q <= '0;
         hw_q <= '0;
         wstream_q <= '0;
         asm_q <= '0;
         data_o <= '0;
      end else begin
         state <= state_nx;
         if (state == S_IDLE && stb_i) begin
            we_q <= we_i;
            odd_q <= addr_i[0];
            n_q <= n_in;
            k_q <= '0;
            sel0_q <= addr_i[0] ? 2'b10 : size_i == 2'd0 ? 2'b01 : 2'b11;
            hw_q <= addr_i[ADDR_WIDTH-1:1];
            wstream_q <= addr_i[0] ? {8'b0, wmask, 8'b0} : {16'b0, wmask};
            asm_q <= '0;
         end else begin
            asm_q <= asm_nx;
            if (seg_done && !last) k_q <= k_q + 2'd1;
            if (seg_done && last) data_o <= odd_q ? asm_nx[39:8] : asm_nx[31:0];
         end
      end
   end
endmodule

// File: tb/tb_psram_bridge.sv
// tb_psram_bridge: directed vectors against a behavioural halfword PSRAM driver model.
module tb_psram_bridge;
   logic clk = 1'b0, rst = 1'b0;
   logic stb = 1'b0, we = 1'b0;
   logic [1:0] size = '0;
   logic [22:0] addr = '0;
   logic [31:0] wdata = '0;
   logic ack, busy, mem_stb, mem_we, mem_ack;
   logic [31:0] rdata, mem_wdata, mem_rdata;
   logic [3:0] mem_sel;
   logic [21:0] mem_addr;
   int tests = 0, fails = 0, stb_cnt = 0, ack_cnt = 0;
   always #5 clk = ~clk;
   psram_bridge dut (
      .clk_i(clk), .rst_i(rst), .stb_i(stb), .we_i(we), .size_i(size), .addr_i(addr),
      .data_i(wdata), .ack_o(ack), .data_o(rdata), .busy_o(busy), .mem_stb_o(mem_stb),
      .mem_we_o(mem_we), .mem_sel_o(mem_sel), .mem_addr_o(mem_addr), .mem_data_o(mem_wdata),
      .mem_ack_i(mem_ack), .mem_data_i(mem_rdata)
   );
   typedef struct {logic we; logic [1:0] sel; logic [21:0] addr; logic [15:0] data;} seg_t;
   seg_t segs[$];
   seg_t cur;
   logic [15:0] mem [logic [21:0]];
   logic [15:0] t;
   logic pend = 1'b0;
   int cnt = 0;
   function automatic logic [15:0] rdm(input logic [21:0] a);
      return mem.exists(a) ? mem[a] : 16'h0;
   endfunction
   // driver model: acks LAT+1 cycles after mem_stb, upper read bits are junk
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         pend <= 1'b0;
         mem_ack <= 1'b0;
      end else begin
         mem_ack <= 1'b0;
         if (pend) begin
            if (cnt == 0) begin
               mem_ack <= 1'b1;
               pend <= 1'b0;
               if (cur.we) begin
                  t = rdm(cur.addr);
                  if (cur.sel[0]) t[7:0] = cur.data[7:0];
                  if (cur.sel[1]) t[15:8] = cur.data[15:8];
                  mem[cur.addr] = t;
               end
               mem_rdata <= {16'hDEAD, rdm(cur.addr)};
            end else cnt <= cnt - 1;
         end else if (mem_stb) begin
            pend <= 1'b1;
            cnt <= 0;
            cur <= '{mem_we, mem_sel[1:0], mem_addr, mem_wdata[15:0]};
            segs.push_back('{mem_we, mem_sel[1:0], mem_addr, mem_wdata[15:0]});
            stb_cnt++;
         end
      end
   end
   always @(negedge clk) if (ack) ack_cnt++;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic do_req(input logic w, input logic [1:0] s, input logic [22:0] a, input logic [31:0] d,
                         output logic [31:0] r, output int cyc);
      @(posedge clk); #1;
      stb = 1'b1; we = w; size = s; addr = a; wdata = d;
      @(posedge clk); #1;
      stb = 1'b0;
      cyc = 1;
      while (!ack && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("ack seen", {31'b0, ack}, 32'd1);
      r = rdata;
   endtask
   typedef struct {logic we; logic [1:0] size; logic [22:0] addr; logic [31:0] wd; logic [31:0] exp; int nseg;} vec_t;
   vec_t v[16];
   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      logic [31:0] r;
      int cyc, s0, a0;
      logic [21:0] ea[3];
      logic [1:0] es[3];
      logic [15:0] ed[3];
      v[0]  = '{1'b1, 2'd2, 23'h000010, 32'h11223344, 32'h0, 2};
      v[1]  = '{1'b0, 2'd2, 23'h000010, 32'h0, 32'h11223344, 2};
      v[2]  = '{1'b1, 2'd2, 23'h000013, 32'hAABBCCDD, 32'h0, 3};
      v[3]  = '{1'b0, 2'd2, 23'h000013, 32'h0, 32'hAABBCCDD, 3};
      v[4]  = '{1'b0, 2'd0, 23'h000013, 32'h0, 32'h000000DD, 1};
      v[5]  = '{1'b1, 2'd1, 23'h7FFFFF, 32'h0000BEEF, 32'h0, 2};
      v[6]  = '{1'b0, 2'd1, 23'h7FFFFF, 32'h0, 32'h0000BEEF, 2};
      v[7]  = '{1'b0, 2'd0, 23'h000010, 32'h0, 32'h00000044, 1};
      v[8]  = '{1'b0, 2'd1, 23'h000011, 32'h0, 32'h00002233, 2};
      v[9]  = '{1'b0, 2'd2, 23'h000010, 32'h0, 32'hDD223344, 2};
      v[10] = '{1'b1, 2'd0, 23'h000012, 32'hFFFFFF5A, 32'h0, 1};
      v[11] = '{1'b0, 2'd2, 23'h000010, 32'h0, 32'hDD5A3344, 2};
      v[12] = '{1'b0, 2'd2, 23'h000014, 32'h0, 32'h00AABBCC, 2};
      v[13] = '{1'b0, 2'd3, 23'h000010, 32'h0, 32'hDD5A3344, 2};
      v[14] = '{1'b0, 2'd0, 23'h000000, 32'h0, 32'h000000BE, 1};
      v[15] = '{1'b0, 2'd0, 23'h7FFFFF, 32'h0, 32'h000000EF, 1};
      #1 rst = 1'b1;
      #1;
      chk("reset ack/busy/stb/we", {28'b0, ack, busy, mem_stb, mem_we}, 32'h0);
      chk("reset sel", {28'b0, mem_sel}, 32'h0);
      chk("reset addr", {10'b0, mem_addr}, 32'h0);
      chk("reset mem_data", mem_wdata, 32'h0);
      chk("reset data", rdata, 32'h0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         s0 = stb_cnt;
         do_req(v[i].we, v[i].size, v[i].addr, v[i].wd, r, cyc);
         if (!v[i].we) chk($sformatf("vec%0d data", i), r, v[i].exp);
`ifndef PSRAM_BRIDGE_RDBUF_EN
         chk($sformatf("vec%0d segs", i), stb_cnt - s0, v[i].nseg);
`else
         if (v[i].we) chk($sformatf("vec%0d segs", i), stb_cnt - s0, v[i].nseg);
`endif
      end
      // three-segment odd word write: lane split and shifted data
      ea = '{22'h9, 22'hA, 22'hB}; es = '{2'b10, 2'b11, 2'b01}; ed = '{16'hDD00, 16'hBBCC, 16'h00AA};
      segs.delete();
      do_req(1'b1, 2'd2, 23'h000013, 32'hAABBCCDD, r, cyc);
      chk("odd word seg count", segs.size(), 3);
      for (int k = 0; k < 3 && k < segs.size(); k++) begin
         chk($sformatf("odd word seg%0d addr", k), {10'b0, segs[k].addr}, {10'b0, ea[k]});
         chk($sformatf("odd word seg%0d sel", k), {30'b0, segs[k].sel}, {30'b0, es[k]});
         chk($sformatf("odd word seg%0d data", k), {16'b0, segs[k].data}, {16'b0, ed[k]});
      end
      // half write at top of memory wraps to halfword 0
      ea[0] = 22'h3FFFFF; ea[1] = 22'h0; es[0] = 2'b10; es[1] = 2'b01; ed[0] = 16'hEF00; ed[1] = 16'h00BE;
      segs.delete();
      do_req(1'b1, 2'd1, 23'h7FFFFF, 32'h0000BEEF, r, cyc);
      chk("wrap seg count", segs.size(), 2);
      for (int k = 0; k < 2 && k < segs.size(); k++) begin
         chk($sformatf("wrap seg%0d addr", k), {10'b0, segs[k].addr}, {10'b0, ea[k]});
         chk($sformatf("wrap seg%0d sel", k), {30'b0, segs[k].sel}, {30'b0, es[k]});
         chk($sformatf("wrap seg%0d data", k), {16'b0, segs[k].data}, {16'b0, ed[k]});
      end
      do_req(1'b1, 2'd0, 23'h000050, 32'h00000077, r, cyc);
      chk("byte latency", cyc, 4);
      chk("busy at ack", {31'b0, busy}, 32'd1);
      @(posedge clk); #1;
      chk("idle after ack", {30'b0, busy, ack}, 32'd0);
      do_req(1'b1, 2'd2, 23'h000050, 32'h01020304, r, cyc);
      chk("word latency", cyc, 7);
      // reset while waiting on the driver
      @(posedge clk); #1;
      stb = 1'b1; we = 1'b1; size = 2'd2; addr = 23'h000040; wdata = 32'hCAFEF00D;
      @(posedge clk); #1;
      stb = 1'b0;
      @(posedge clk); #1;
      chk("in wait we", {31'b0, mem_we}, 32'd1);
      a0 = ack_cnt;
      rst = 1'b1;
      #1;
      chk("midreset ack/busy/stb/we", {28'b0, ack, busy, mem_stb, mem_we}, 32'h0);
      chk("midreset sel", {28'b0, mem_sel}, 32'h0);
      chk("midreset addr", {10'b0, mem_addr}, 32'h0);
      chk("midreset mem_data", mem_wdata, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("no ack after reset", ack_cnt - a0, 0);
      do_req(1'b0, 2'd2, 23'h000010, 32'h0, r, cyc);
      chk("read after reset", r, 32'hDD5A3344);
`ifdef PSRAM_BRIDGE_RDBUF_EN
      do_req(1'b1, 2'd1, 23'h000020, 32'h00001234, r, cyc);
      s0 = stb_cnt;
      do_req(1'b0, 2'd1, 23'h000020, 32'h0, r, cyc);
      chk("rdbuf miss stb", stb_cnt - s0, 1);
      chk("rdbuf miss data", r, 32'h00001234);
      s0 = stb_cnt;
      do_req(1'b0, 2'd1, 23'h000020, 32'h0, r, cyc);
      chk("rdbuf hit stb", stb_cnt - s0, 0);
      chk("rdbuf hit latency", cyc, 2);
      chk("rdbuf hit data", r, 32'h00001234);
      do_req(1'b1, 2'd0, 23'h000021, 32'h00000099, r, cyc);
      s0 = stb_cnt;
      do_req(1'b0, 2'd1, 23'h000020, 32'h0, r, cyc);
      chk("rdbuf invalidated stb", stb_cnt - s0, 1);
      chk("rdbuf invalidated data", r, 32'h00009934);
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
